// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus IF/ID latch with redirect, stall, flush and range halt.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;
  state_t      state_q;
  logic [31:0] pc_q, instr_q, pc4_q, count_q, pc_plus4, tgt, pc_d;
  logic        valid_q, misalign_q, fault_q, redirect, fault, mis, active;
  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = jump | branch_taken;
  assign tgt      = jump ? {pc_plus4[31:28], jump_index, 2'b00} : branch_target;
  assign pc_d     = redirect ? {tgt[31:2], 2'b00} : stall ? pc_q : pc_plus4;
  assign mis      = branch_taken & ~jump & (|branch_target[1:0]);
  assign fault    = (pc_d[31:10] != 22'd0) || ({24'd0, pc_d[9:2]} >= 32'(IMEM_WORDS));
  assign active   = (state_q == RUN) || (state_q == STALL);
  // BOOT spends one edge with the pc held so the first word has settled before it is latched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      misalign_q <= 1'b0;
      if (state_q == BOOT) begin
        state_q <= RUN;
      end else if (active) begin
        misalign_q <= mis;
        if (fault) begin
          state_q <= HALT;
          fault_q <= 1'b1;
          valid_q <= 1'b0;
        end else begin
          pc_q    <= pc_d;
          state_q <= (stall && !redirect) ? STALL : RUN;
          valid_q <= !redirect && (stall ? valid_q : 1'b1);
          if (!redirect && !stall) begin
            instr_q <= instr_in;
            pc4_q   <= pc_plus4;
            count_q <= count_q + 32'd1;
          end
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign misalign    = misalign_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch sequencing, redirect, stall, misalign and halt.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target, instr_in;
  logic [25:0] jump_index;
  logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, misalign, fetch_fault;
  int          n_tests = 0;
  int          n_fail  = 0;
  always #5 clk = ~clk;
  assign instr_in = {16'hC0DE, pc[15:0]};
  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .instr_in(instr_in), .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .misalign(misalign), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; branch_target = '0; jump_index = '0;
  endtask
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    reset = 1'b0;
    step();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
    step();
    chk("seq1_pc", pc, 32'h4);
    chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("seq1_pc4", if_id_pc4, 32'h4);
    chk("seq1_instr", if_id_instr, 32'hC0DE_0000);
    step();
    chk("seq2_pc", pc, 32'h8);
    chk("seq2_pc4", if_id_pc4, 32'h8);
    step();
    chk("seq3_pc", pc, 32'hC);
    chk("seq3_pc4", if_id_pc4, 32'hC);
    chk("seq3_count", fetch_count, 32'd3);
    step();
    chk("seq4_pc", pc, 32'h10);
    chk("seq4_count", fetch_count, 32'd4);
    // three stalled edges at pc 0x10
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h10);
      chk("stall_pc4", if_id_pc4, 32'h10);
      chk("stall_instr", if_id_instr, 32'hC0DE_000C);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
      chk("stall_count", fetch_count, 32'd4);
    end
    stall = 0;
    step();
    chk("resume_pc", pc, 32'h14);
    chk("resume_pc4", if_id_pc4, 32'h14);
    chk("resume_instr", if_id_instr, 32'hC0DE_0010);
    chk("resume_count", fetch_count, 32'd5);
    // jump overrides stall: target {0, 7, 00} = 0x1C
    stall = 1; jump = 1; jump_index = 26'd7;
    step();
    chk("jmp_pc", pc, 32'h1C);
    chk("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    chk("jmp_count", fetch_count, 32'd5);
    idle();
    step();
    chk("jmp_next_pc", pc, 32'h20);
    chk("jmp_next_instr", if_id_instr, 32'hC0DE_001C);
    chk("jmp_next_valid", {31'd0, if_id_valid}, 32'd1);
    chk("jmp_next_count", fetch_count, 32'd6);
    branch_taken = 1; branch_target = 32'h40;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_valid", {31'd0, if_id_valid}, 32'd0);
    chk("br_mis", {31'd0, misalign}, 32'd0);
    chk("br_count", fetch_count, 32'd6);
    idle();
    step();
    chk("br_next_pc", pc, 32'h44);
    chk("br_next_pc4", if_id_pc4, 32'h44);
    chk("br_next_valid", {31'd0, if_id_valid}, 32'd1);
    chk("br_next_count", fetch_count, 32'd7);
    branch_taken = 1; branch_target = 32'h22;
    step();
    chk("mis_pc", pc, 32'h20);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    idle();
    step();
    chk("mis_next_pc", pc, 32'h24);
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_next_pc4", if_id_pc4, 32'h24);
    chk("mis_next_count", fetch_count, 32'd8);
    // jump and branch together: jump target 0x40 wins, branch to 0x8 ignored
    jump = 1; jump_index = 26'h10; branch_taken = 1; branch_target = 32'h8;
    step();
    chk("both_pc", pc, 32'h40);
    chk("both_valid", {31'd0, if_id_valid}, 32'd0);
    idle();
    step();
    chk("both_next_pc", pc, 32'h44);
    chk("both_next_count", fetch_count, 32'd9);
    branch_taken = 1; branch_target = 32'h78;
    step();
    chk("edge_br_pc", pc, 32'h78);
    idle();
    step();
    chk("edge_pc", pc, 32'h7C);
    chk("edge_count", fetch_count, 32'd10);
    chk("edge_fault", {31'd0, fetch_fault}, 32'd0);
    step();
    chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
    chk("halt_pc", pc, 32'h7C);
    chk("halt_valid", {31'd0, if_id_valid}, 32'd0);
    chk("halt_count", fetch_count, 32'd10);
    branch_taken = 1; branch_target = 32'h0;
    step();
    chk("halt_hold_pc", pc, 32'h7C);
    chk("halt_sticky", {31'd0, fetch_fault}, 32'd1);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_fault", {31'd0, fetch_fault}, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    chk("async_pc4", if_id_pc4, 32'h0);
    chk("async_instr", if_id_instr, 32'h0);
    #3 reset = 1'b0;
    step();
    step();
    chk("hi_pre_pc", pc, 32'h4);
    // upper address bits out of range
    branch_taken = 1; branch_target = 32'h400;
    step();
    chk("hi_fault", {31'd0, fetch_fault}, 32'd1);
    chk("hi_pc", pc, 32'h4);
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
